// File: rtl/knn_pkg.sv
// Shared KNN definitions: default geometry, distance-stage FSM states and burst arithmetic.
package knn_pkg;

  localparam int unsigned KNN_M            = 5;
  localparam int unsigned KNN_N            = 10;
  localparam int unsigned KNN_W            = 32;
  localparam int unsigned KNN_MAX_ELEMENTS = 30;
  localparam int unsigned KNN_TYPE_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_WAIT_DATA,
    ST_DONE
  } state_e;

  // Number of bursts needed to carry all elements of one sample.
  function automatic int unsigned burst_count(input int unsigned total,
                                              input int unsigned max_el);
    return (total + max_el - 1) / max_el;
  endfunction

endpackage

// File: rtl/sq_diff_acc.sv
// Squared-difference accumulator: acc += |a-b|^2, saturating at all-ones.
module sq_diff_acc #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   diff;
  logic [2*W-1:0] sq;
  logic [2*W:0]   sum;

  always_comb begin
    diff = (a_i > b_i) ? (a_i - b_i) : (b_i - a_i);
    sq   = {{W{1'b0}}, diff} * {{W{1'b0}}, diff};
    sum  = {{(W+1){1'b0}}, acc_q} + {1'b0, sq};
    // Any bit above W means the true sum no longer fits; pin to the ceiling.
    acc_d = (|sum[2*W:W]) ? '1 : sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/distance_calculator.sv
// KNN distance stage: accumulates squared Euclidean distance over bursts of elements.
module distance_calculator
  import knn_pkg::*;
#(
  parameter int unsigned M            = KNN_M,
  parameter int unsigned N            = KNN_N,
  parameter int unsigned W            = KNN_W,
  parameter int unsigned MAX_ELEMENTS = KNN_MAX_ELEMENTS,
  parameter int unsigned TYPE_W       = KNN_TYPE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ready,
  input  logic [W*MAX_ELEMENTS-1:0] training_data,
  input  logic [TYPE_W-1:0]         training_data_type,
  input  logic [W*MAX_ELEMENTS-1:0] input_data,
  output logic [W-1:0]              distance,
  output logic [TYPE_W-1:0]         data_type,
  output logic                      done,
  output logic                      data_request
);

  localparam int unsigned TOTAL    = M * N;
  localparam int unsigned NB       = burst_count(TOTAL, MAX_ELEMENTS);
  localparam int unsigned LAST_LEN = TOTAL - (NB - 1) * MAX_ELEMENTS;
  localparam int unsigned LEN_W    = $clog2(MAX_ELEMENTS + 1);
  localparam int unsigned BW       = $clog2(NB + 1);

  state_e                    state_q;
  logic [W*MAX_ELEMENTS-1:0] t_q, i_q;
  logic [LEN_W-1:0]          idx_q;
  logic [BW-1:0]             burst_q;
  logic [W-1:0]              distance_q;
  logic [TYPE_W-1:0]         data_type_q;
  logic                      done_q, req_q;

  logic             last_burst;
  logic [LEN_W-1:0] len;
  logic             acc_en, start;
  logic [W-1:0]     t_el, i_el, acc;

  always_comb begin
    last_burst = (burst_q == BW'(NB - 1));
    len        = last_burst ? LEN_W'(LAST_LEN) : LEN_W'(MAX_ELEMENTS);
    acc_en     = (state_q == ST_ACC) && (idx_q < len);
    start      = ready && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

  // Constant-slice mux keeps the one-past-the-end index from selecting out of range.
  always_comb begin
    t_el = '0;
    i_el = '0;
    for (int unsigned k = 0; k < MAX_ELEMENTS; k++) begin
      if (idx_q == LEN_W'(k)) begin
        t_el = t_q[k*W +: W];
        i_el = i_q[k*W +: W];
      end
    end
  end

  sq_diff_acc #(.W(W)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start),
    .en_i  (acc_en),
    .a_i   (t_el),
    .b_i   (i_el),
    .acc_o (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      i_q         <= '0;
      idx_q       <= '0;
      burst_q     <= '0;
      distance_q  <= '0;
      data_type_q <= '0;
      done_q      <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (ready) begin
            t_q         <= training_data;
            i_q         <= input_data;
            idx_q       <= '0;
            burst_q     <= '0;
            data_type_q <= training_data_type;
            done_q      <= 1'b0;
            state_q     <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (idx_q < len) begin
            idx_q <= idx_q + LEN_W'(1);
          end else if (last_burst) begin
            distance_q <= acc;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            burst_q <= burst_q + BW'(1);
            req_q   <= 1'b1;
            state_q <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (ready) begin
            t_q     <= training_data;
            i_q     <= input_data;
            idx_q   <= '0;
            req_q   <= 1'b0;
            state_q <= ST_ACC;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign distance     = distance_q;
  assign data_type    = data_type_q;
  assign done         = done_q;
  assign data_request = req_q;

endmodule

// File: tb/tb_distance_calculator.sv
// Directed bench for distance_calculator across three geometries.
module tb_distance_calculator;

  localparam int unsigned MX = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: 2x3, W=32
  logic              rdy_a = 1'b0;
  logic [32*MX-1:0]  td_a = '0, id_a = '0;
  logic [1:0]        tt_a = '0;
  logic [31:0]       dist_a;
  logic [1:0]        type_a;
  logic              done_a, req_a;

  // Instance B: 60x10, W=32 (20 bursts)
  logic              rdy_b = 1'b0;
  logic [32*MX-1:0]  td_b = '0, id_b = '0;
  logic [1:0]        tt_b = '0;
  logic [31:0]       dist_b;
  logic [1:0]        type_b;
  logic              done_b, req_b;

  // Instance C: 1x2, W=8
  logic              rdy_c = 1'b0;
  logic [8*MX-1:0]   td_c = '0, id_c = '0;
  logic [1:0]        tt_c = '0;
  logic [7:0]        dist_c;
  logic [1:0]        type_c;
  logic              done_c, req_c;

  distance_calculator #(.M(2), .N(3), .W(32), .MAX_ELEMENTS(MX), .TYPE_W(2)) u_a (
    .clk(clk), .rst(rst), .ready(rdy_a), .training_data(td_a), .training_data_type(tt_a),
    .input_data(id_a), .distance(dist_a), .data_type(type_a), .done(done_a), .data_request(req_a));

  distance_calculator #(.M(60), .N(10), .W(32), .MAX_ELEMENTS(MX), .TYPE_W(2)) u_b (
    .clk(clk), .rst(rst), .ready(rdy_b), .training_data(td_b), .training_data_type(tt_b),
    .input_data(id_b), .distance(dist_b), .data_type(type_b), .done(done_b), .data_request(req_b));

  distance_calculator #(.M(1), .N(2), .W(8), .MAX_ELEMENTS(MX), .TYPE_W(2)) u_c (
    .clk(clk), .rst(rst), .ready(rdy_c), .training_data(td_c), .training_data_type(tt_c),
    .input_data(id_c), .distance(dist_c), .data_type(type_c), .done(done_c), .data_request(req_c));

  bit req_seen_a = 1'b0;
  bit both_hi    = 1'b0;
  always @(posedge clk) begin
    if (req_a) req_seen_a <= 1'b1;
    if ((done_a && req_a) || (done_b && req_b) || (done_c && req_c)) both_hi <= 1'b1;
  end

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: rdy_a = 1'b1;
      1: rdy_b = 1'b1;
      default: rdy_c = 1'b1;
    endcase
    @(posedge clk);
    #1;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
  endtask

  // Cycles after the ready edge until done or data_request shows up (bounded).
  task automatic wait_evt(input int which, input int budget, output int cycles);
    logic hit;
    cycles = 0;
    hit    = 1'b0;
    while (!hit && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      case (which)
        0: hit = done_a || req_a;
        1: hit = done_b || req_b;
        default: hit = done_c || req_c;
      endcase
    end
  endtask

  initial begin
    int cyc, nreq;
    longint unsigned exp;
    int tv, iv;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dist",  dist_a, 0);
    check("rst_type",  type_a, 0);
    check("rst_done",  done_a, 0);
    check("rst_req",   req_a,  0);
    check("rst_req_b", req_b,  0);
    @(negedge clk);
    rst = 1'b0;

    // All-ones minus zeros over 6 elements
    for (int k = 0; k < 6; k++) td_a[k*32 +: 32] = 32'd1;
    tt_a = 2'd1;
    pulse(0);
    wait_evt(0, 20, cyc);
    check("a1_latency", cyc, 7);
    check("a1_done", done_a, 1);
    check("a1_dist", dist_a, 6);
    check("a1_type", type_a, 1);

    // (3-0)^2 + (0-4)^2 = 25
    td_a = '0; id_a = '0;
    td_a[31:0] = 32'd3;
    id_a[63:32] = 32'd4;
    tt_a = 2'd2;
    pulse(0);
    check("a2_done_cleared", done_a, 0);
    check("a2_dist_held", dist_a, 6);
    wait_evt(0, 20, cyc);
    check("a2_latency", cyc, 7);
    check("a2_dist", dist_a, 25);
    check("a2_type", type_a, 2);
    check("a_req_never", req_seen_a, 0);

    // 20 bursts of 30 ones each
    for (int k = 0; k < int'(MX); k++) td_b[k*32 +: 32] = 32'd1;
    tt_b = 2'd3;
    nreq = 0;
    for (int b = 0; b < 25; b++) begin
      pulse(1);
      wait_evt(1, 40, cyc);
      if (b == 0) check("b_latency", cyc, 31);
      if (req_b) nreq++;
      if (!req_b) break;
    end
    check("b_nreq", nreq, 19);
    check("b_done", done_b, 1);
    check("b_dist", dist_b, 600);
    check("b_type", type_b, 3);

    // Three back-to-back runs with random operands
    for (int r = 0; r < 3; r++) begin
      exp = 0;
      td_a = '0; id_a = '0;
      for (int k = 0; k < 6; k++) begin
        tv = int'($urandom_range(300));
        iv = int'($urandom_range(300));
        td_a[k*32 +: 32] = 32'(tv);
        id_a[k*32 +: 32] = 32'(iv);
        exp += longint'((tv - iv) * (tv - iv));
      end
      tt_a = 2'(r + 1);
      pulse(0);
      wait_evt(0, 20, cyc);
      check("rnd_done", done_a, 1);
      check("rnd_dist", dist_a, exp);
      check("rnd_type", type_a, r + 1);
    end

    // W=8 saturation, then a small in-range case
    td_c[7:0] = 8'd255; td_c[15:8] = 8'd255;
    tt_c = 2'd1;
    pulse(2);
    wait_evt(2, 10, cyc);
    check("c_latency", cyc, 3);
    check("c_sat", dist_c, 255);
    td_c[7:0] = 8'd3; td_c[15:8] = 8'd2; id_c[7:0] = 8'd1; id_c[15:8] = 8'd0;
    pulse(2);
    wait_evt(2, 10, cyc);
    check("c_small", dist_c, 8);

    // Reset mid-accumulation
    td_a = '0; id_a = '0;
    for (int k = 0; k < 6; k++) td_a[k*32 +: 32] = 32'd1;
    tt_a = 2'd3;
    pulse(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_dist", dist_a, 0);
    check("mid_rst_type", type_a, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_req",  req_a,  0);

    // ready coincident with reset must be ignored
    @(negedge clk);
    rdy_a = 1'b1;
    @(posedge clk);
    #1;
    rdy_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("rst_ready_ignored", done_a, 0);

    pulse(0);
    wait_evt(0, 20, cyc);
    check("fresh_latency", cyc, 7);
    check("fresh_dist", dist_a, 6);
    check("fresh_type", type_a, 3);
    check("never_both_high", both_hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/distance_calculator.md
# distance_calculator

Accumulates the squared Euclidean distance between one training vector and one input vector, each M×N unsigned W-bit elements. Data arrives in bursts of at most MAX_ELEMENTS elements. The block also passes the training sample's class label through to its output. It is the distance stage of the KNN system: the loader feeds bursts in, and the classifier consumes `distance` and `data_type` when `done` rises.

## Interface
Parameters:
- M, 5: rows of a sample.
- N, 10: columns of a sample; TOTAL = M*N elements.
- W, 32: element and distance width.
- MAX_ELEMENTS, 30: burst capacity in elements.
- TYPE_W, 2: class-label width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- ready  in  1  one-cycle strobe: the current burst on the data ports is valid.
- training_data  in  W*MAX_ELEMENTS  burst of training elements; element k is at [k*W +: W].
- training_data_type  in  TYPE_W  class label of the training sample.
- input_data  in  W*MAX_ELEMENTS  burst of input elements, same packing as training_data.
- distance  out  W  final squared distance.
- data_type  out  TYPE_W  label latched with the first burst.
- done  out  1  result valid.
- data_request  out  1  current burst consumed; more elements are needed.

## Operation
- A run is ceil(TOTAL/MAX_ELEMENTS) bursts.
  - Each burst carries L = MAX_ELEMENTS elements, except the last, which carries TOTAL − (bursts−1)·MAX_ELEMENTS.
  - If TOTAL ≤ MAX_ELEMENTS, a run is a single burst of TOTAL elements.
- FSM states: IDLE, ACC, WAIT_DATA, DONE.
  - IDLE/DONE + ready: latch both bursts. On the first burst of a run, also clear the accumulator, latch training_data_type into data_type, set the element counter to 0, and clear done. Go to ACC.
  - ACC: process one element per cycle: d = |t−i| (unsigned), acc += d·d.
  - ACC, burst exhausted, elements remaining: go to WAIT_DATA with data_request = 1.
  - ACC, last element processed: distance ← acc, done = 1, go to DONE.
  - WAIT_DATA + ready: latch the next burst, drop data_request, go to ACC.
- Arithmetic:
  - The square is 2W bits wide.
  - The accumulator saturates at 2^W−1: once saturated it stays saturated for the rest of the run.
- `ready` is ignored while in ACC.
- done and data_request are levels.
  - Each is held until the next accepted `ready`.
  - They are never high together.
- distance and data_type hold their values until overwritten by the next run.

## Timing
- Reset values: distance = 0, data_type = 0, done = 0, data_request = 0; state = IDLE; accumulator and counters = 0.
- Reset mid-run aborts the run immediately. The next `ready` starts a new run.
- Burst latency:
  - `ready` is sampled at edge E0.
  - Elements are accumulated at edges E1..EL.
  - done or data_request is high after edge E(L+1), i.e. L+1 cycles after the ready edge.
- Total run time: TOTAL cycles of accumulation plus one per burst, excluding source wait time.
- ready coincident with rst: reset wins.

## Structure
- Shared package `knn_pkg`:
  - state enum;
  - default constants M, N, W, MAX_ELEMENTS, TYPE_W;
  - helper function for the burst count, ceil(M*N/MAX_ELEMENTS).
- One natural sub-module: `sq_diff_acc`, covering absolute difference, square and saturating add with clear/enable. The FSM, counters and burst registers stay in the top level.

## Test plan
- M=2, N=3, MAX=30; all training=1, input=0; one ready → done after 7 cycles, distance=6, data_request never high.
- Same config; training={3,0,0,0,0,0}, input={0,4,0,0,0,0}, type=2 → distance=25, data_type=2.
- M=60, N=10, MAX=30; all training=1, input=0; 20 bursts, each ready issued after data_request → data_request asserted 19 times, then done with distance=600.
- Random values in 0..300 across three back-to-back runs → distance equals the reference sum of squared differences; data_type equals the label latched with each run's first burst.
- W=8, M=1, N=2; training={255,255}, input={0,0} → distance=255 (saturated).
- rst asserted mid-ACC, then a fresh run with all training=1, input=0 → outputs return to 0 the cycle after rst; the fresh run's distance equals TOTAL.
